// File: rtl/pe_relay_rr4.sv
// Relay PE that forwards words between the four mesh neighbours (0=E,1=W,2=N,3=S).
// Each input has a small FIFO; each output has a round-robin arbiter feeding a registered stage.
module pe_relay_rr4 #(
    parameter int DATA_WIDTH = 130,
    parameter int FIFO_AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ap_start,
    input  logic [7:0]            cfg_route,
    input  logic [DATA_WIDTH-1:0] in_from_east,
    input  logic [DATA_WIDTH-1:0] in_from_west,
    input  logic [DATA_WIDTH-1:0] in_from_north,
    input  logic [DATA_WIDTH-1:0] in_from_south,
    input  logic [3:0]            in_valid,
    output logic [3:0]            in_ready,
    output logic [DATA_WIDTH-1:0] out_to_east,
    output logic [DATA_WIDTH-1:0] out_to_west,
    output logic [DATA_WIDTH-1:0] out_to_north,
    output logic [DATA_WIDTH-1:0] out_to_south,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic                  busy
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_W = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [7:0]            route_q, route_d;

    logic [DATA_WIDTH-1:0] in_data [4];
    logic [DATA_WIDTH-1:0] head [4];
    logic [FIFO_AW:0]      count_q [4];
    logic [FIFO_AW-1:0]    wr_ptr_q [4];
    logic [FIFO_AW-1:0]    rd_ptr_q [4];
    logic [3:0]            push, pop, empty, full;

    logic [1:0]            rr_q [4];
    logic [1:0]            rr_d [4];
    logic [DATA_WIDTH-1:0] out_data_q [4];
    logic [DATA_WIDTH-1:0] out_data_d [4];
    logic [3:0]            out_valid_q, out_valid_d;

    logic                  found;
    logic [1:0]            win, idx;

    assign in_data[0] = in_from_east;
    assign in_data[1] = in_from_west;
    assign in_data[2] = in_from_north;
    assign in_data[3] = in_from_south;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    // The route table is only captured on the IDLE->RUN edge; DRAIN->RUN keeps it.
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d = RUN;
                    route_d = cfg_route;
                end
            end
            RUN: begin
                if (!ap_start) state_d = DRAIN;
            end
            DRAIN: begin
                if (ap_start)
                    state_d = RUN;
                else if (empty == 4'hF && out_valid_q == 4'h0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        for (int d = 0; d < 4; d++)
            in_ready[d] = (state_q == RUN) && !full[d];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];

        assign empty[gi] = (count_q[gi] == '0);
        assign full[gi]  = (count_q[gi] == DEPTH_W);
        assign push[gi]  = in_valid[gi] && in_ready[gi];
        assign head[gi]  = mem_q[rd_ptr_q[gi]];

        always_ff @(posedge clk) begin
            if (push[gi]) mem_q[wr_ptr_q[gi]] <= in_data[gi];
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                count_q[gi]  <= '0;
                wr_ptr_q[gi] <= '0;
                rd_ptr_q[gi] <= '0;
            end else begin
                if (push[gi]) wr_ptr_q[gi] <= wr_ptr_q[gi] + 1'b1;
                if (pop[gi])  rd_ptr_q[gi] <= rd_ptr_q[gi] + 1'b1;
                case ({push[gi], pop[gi]})
                    2'b10:   count_q[gi] <= count_q[gi] + 1'b1;
                    2'b01:   count_q[gi] <= count_q[gi] - 1'b1;
                    default: count_q[gi] <= count_q[gi];
                endcase
            end
        end
    end

    // Each input maps to exactly one output, so at most one arbiter can pop a given FIFO.
    always_comb begin
        pop   = '0;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int o = 0; o < 4; o++) begin
            out_valid_d[o] = out_valid_q[o];
            out_data_d[o]  = out_data_q[o];
            rr_d[o]        = rr_q[o];
            found          = 1'b0;
            win            = rr_q[o];
            for (int k = 0; k < 4; k++) begin
                idx = rr_q[o] + 2'(k);
                if (!found && !empty[idx] && route_q[{idx, 1'b0} +: 2] == 2'(o)) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            if (!out_valid_q[o] || out_ready[o]) begin
                if (found) begin
                    pop[win]       = 1'b1;
                    out_valid_d[o] = 1'b1;
                    out_data_d[o]  = head[win];
                    rr_d[o]        = win + 2'd1;
                end else begin
                    out_valid_d[o] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= '0;
            for (int o = 0; o < 4; o++) begin
                out_data_q[o] <= '0;
                rr_q[o]       <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            for (int o = 0; o < 4; o++) begin
                out_data_q[o] <= out_data_d[o];
                rr_q[o]       <= rr_d[o];
            end
        end
    end

    assign out_to_east  = out_data_q[0];
    assign out_to_west  = out_data_q[1];
    assign out_to_north = out_data_q[2];
    assign out_to_south = out_data_q[3];
    assign out_valid    = out_valid_q;
endmodule
